// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 7-input mux scan sequencer.
// The select helper saturates at the last input so the select can never reach 7.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NUM_INPUTS = 7;
  localparam int SEL_W      = 3;
  localparam logic [SEL_W-1:0] LAST_SEL = 3'd6;

  function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] sel);
    return (sel == LAST_SEL) ? LAST_SEL : (sel + 3'd1);
  endfunction

endpackage

// File: rtl/rate_divider.sv
// Dwell counter: Tick is high on the terminal count while enabled.
// The counter only advances while enabled, so a paused scan resumes where it stopped.
module rate_divider
  import mux_scan_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Clear,
  input  logic Enable,
  output logic Tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_n;
  logic             terminal_s;

  assign terminal_s = (count_r == TERM);
  assign Tick       = Enable & terminal_s;

  // next count: clear on launch, wrap at terminal, freeze when disabled
  always_comb begin
    count_n = count_r;
    if (Clear) begin
      count_n = {CNT_W{1'b0}};
    end else if (Enable) begin
      count_n = terminal_s ? {CNT_W{1'b0}} : (count_r + CNT_W'(1));
    end else begin
      count_n = count_r;
    end
  end

  // count register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      count_r <= count_n;
    end
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Walks the mux select through 0..6, samples MuxOut at the end of each dwell
// and assembles the samples into Captured. All outputs are registered.
module mux_scan_sequencer #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int NUM_INPUTS = 7
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  Hold,
  input  logic                  MuxOut,
  output logic [2:0]            MuxSelect,
  output logic [NUM_INPUTS-1:0] Captured,
  output logic                  Step,
  output logic                  Busy,
  output logic                  Done
);

  import mux_scan_pkg::*;

  state_t                state_r;
  state_t                state_n;
  logic [SEL_W-1:0]      sel_r;
  logic [SEL_W-1:0]      sel_n;
  logic [NUM_INPUTS-1:0] cap_r;
  logic [NUM_INPUTS-1:0] cap_n;
  logic                  step_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  launch_s;
  logic                  enable_s;
  logic                  tick_s;

  // Start only counts outside RUN; busy_r mirrors state_r == RUN
  assign launch_s = Start & (state_r != RUN);
  assign enable_s = busy_r & ~Hold;

  rate_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_div (
    .Clock (Clock),
    .Reset (Reset),
    .Clear (launch_s),
    .Enable(enable_s),
    .Tick  (tick_s)
  );

  // next state, select and capture word
  always_comb begin
    state_n = state_r;
    sel_n   = sel_r;
    cap_n   = cap_r;
    case (state_r)
      IDLE, DONE: begin
        if (Start) begin
          state_n = RUN;
          sel_n   = {SEL_W{1'b0}};
          cap_n   = {NUM_INPUTS{1'b0}};
        end else begin
          state_n = state_r;
        end
      end
      RUN: begin
        if (tick_s) begin
          cap_n[sel_r] = MuxOut;
          if (sel_r == LAST_SEL) begin
            state_n = DONE;
          end else begin
            sel_n = next_sel(sel_r);
          end
        end else begin
          state_n = state_r;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // state register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // output registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sel_r  <= {SEL_W{1'b0}};
      cap_r  <= {NUM_INPUTS{1'b0}};
      step_r <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      sel_r  <= sel_n;
      cap_r  <= cap_n;
      step_r <= tick_s;
      busy_r <= (state_n == RUN);
      done_r <= (state_n == DONE);
    end
  end

  assign MuxSelect = sel_r;
  assign Captured  = cap_r;
  assign Step      = step_r;
  assign Busy      = busy_r;
  assign Done      = done_r;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: two instances (dwell 4 and dwell 1) share stimulus,
// a per-cycle scan model, a vector table, hand sequences and a random phase.
module tb_mux_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       hold;
  logic [6:0] pat;

  logic [2:0] sel4, sel1;
  logic [6:0] cap4, cap1;
  logic       step4, step1, busy4, busy1, done4, done1;
  logic       mux4, mux1;

  int tests = 0;
  int fails = 0;

  // downstream mux: combinational pick of the pattern bit
  assign mux4 = (sel4 <= 3'd6) ? pat[sel4] : 1'b0;
  assign mux1 = (sel1 <= 3'd6) ? pat[sel1] : 1'b0;

  always #5 clk = ~clk;

  mux_scan_sequencer #(.TICK_DIV(4), .NUM_INPUTS(7)) dut4 (
    .Clock(clk), .Reset(rst), .Start(start), .Hold(hold), .MuxOut(mux4),
    .MuxSelect(sel4), .Captured(cap4), .Step(step4), .Busy(busy4), .Done(done4)
  );

  mux_scan_sequencer #(.TICK_DIV(1), .NUM_INPUTS(7)) dut1 (
    .Clock(clk), .Reset(rst), .Start(start), .Hold(hold), .MuxOut(mux1),
    .MuxSelect(sel1), .Captured(cap1), .Step(step1), .Busy(busy1), .Done(done1)
  );

  // Model: a scan is 7*T un-held RUN cycles; sample k lands when units == (k+1)*T.
  int       units [2];
  bit       mrun  [2];
  bit [6:0] mcap  [2];
  bit [2:0] msel  [2];
  bit       mstep [2];
  bit       mdone [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int d, input int t);
    int k;
    mstep[d] = 1'b0;
    if (rst) begin
      mrun[d] = 1'b0; units[d] = 0; mcap[d] = 7'd0; msel[d] = 3'd0; mdone[d] = 1'b0;
    end else if (!mrun[d] && start) begin
      mrun[d] = 1'b1; units[d] = 0; mcap[d] = 7'd0; msel[d] = 3'd0; mdone[d] = 1'b0;
    end else if (mrun[d] && !hold) begin
      units[d]++;
      if (units[d] % t == 0) begin
        k = units[d] / t - 1;
        mcap[d][k] = pat[k];
        mstep[d] = 1'b1;
        if (k == 6) begin
          mrun[d] = 1'b0;
          mdone[d] = 1'b1;
        end else begin
          msel[d] = 3'(k + 1);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step(0, 4);
    model_step(1, 1);
    check("model_sel4",  sel4,  msel[0]);
    check("model_cap4",  cap4,  mcap[0]);
    check("model_step4", step4, mstep[0]);
    check("model_busy4", busy4, mrun[0]);
    check("model_done4", done4, mdone[0]);
    check("model_sel1",  sel1,  msel[1]);
    check("model_cap1",  cap1,  mcap[1]);
    check("model_step1", step1, mstep[1]);
    check("model_busy1", busy1, mrun[1]);
    check("model_done1", done1, mdone[1]);
  endtask

  typedef struct {
    logic [6:0] pattern;
    int         hold_at;
    int         hold_len;
    int         restart_at;
    int         exp_done4;
    int         exp_done1;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int d4, d1, s4, s1;

    vecs[0] = '{7'b1010011, 0,  0, 0, 28, 7};
    vecs[1] = '{7'b0101100, 0,  0, 5, 28, 7};
    vecs[2] = '{7'b1100101, 10, 3, 0, 31, 7};
    vecs[3] = '{7'b0011010, 3,  2, 0, 30, 9};

    // reset with Start held high
    rst = 1'b1; start = 1'b1; hold = 1'b0; pat = 7'b1111111;
    tick();
    tick();
    check("rst_sel4", sel4, 3'd0);  check("rst_cap4", cap4, 7'd0);
    check("rst_step4", step4, 1'b0); check("rst_busy4", busy4, 1'b0);
    check("rst_done4", done4, 1'b0);
    check("rst_sel1", sel1, 3'd0);  check("rst_cap1", cap1, 7'd0);
    check("rst_busy1", busy1, 1'b0); check("rst_done1", done1, 1'b0);
    rst = 1'b0; start = 1'b0;
    for (int n = 0; n < 3; n++) tick();
    check("idle_busy4", busy4, 1'b0); check("idle_busy1", busy1, 1'b0);
    check("idle_done4", done4, 1'b0);

    // table: full scans, restart while busy, hold, relaunch from DONE
    for (int r = 0; r < 4; r++) begin
      pat = vecs[r].pattern;
      start = 1'b1; hold = 1'b0;
      tick();
      start = 1'b0;
      check("launch_busy4", busy4, 1'b1); check("launch_sel4", sel4, 3'd0);
      check("launch_cap4", cap4, 7'd0);   check("launch_cap1", cap1, 7'd0);
      d4 = -1; d1 = -1; s4 = 0; s1 = 0;
      for (int n = 1; n <= 40; n++) begin
        hold  = (n >= vecs[r].hold_at) && (n < vecs[r].hold_at + vecs[r].hold_len);
        start = (vecs[r].restart_at != 0) && (n == vecs[r].restart_at);
        tick();
        if (done4 && d4 < 0) d4 = n;
        if (done1 && d1 < 0) d1 = n;
        s4 += int'(step4);
        s1 += int'(step1);
      end
      hold = 1'b0; start = 1'b0;
      check($sformatf("vec%0d_done4_cycle", r), d4, vecs[r].exp_done4);
      check($sformatf("vec%0d_done1_cycle", r), d1, vecs[r].exp_done1);
      check($sformatf("vec%0d_steps4", r), s4, 7);
      check($sformatf("vec%0d_steps1", r), s1, 7);
      check($sformatf("vec%0d_cap4", r), cap4, vecs[r].pattern);
      check($sformatf("vec%0d_cap1", r), cap1, vecs[r].pattern);
      check($sformatf("vec%0d_sel4", r), sel4, 3'd6);
      check($sformatf("vec%0d_busy4", r), busy4, 1'b0);
    end

    // reset after two samples, then a clean rescan
    pat = 7'b1011001;
    start = 1'b1; tick(); start = 1'b0;
    for (int n = 1; n <= 8; n++) tick();
    check("mid_sel4", sel4, 3'd2);
    check("mid_cap4", cap4, 7'b0000001);
    rst = 1'b1; tick(); rst = 1'b0;
    check("midrst_sel4", sel4, 3'd0);  check("midrst_cap4", cap4, 7'd0);
    check("midrst_busy4", busy4, 1'b0); check("midrst_step4", step4, 1'b0);
    check("midrst_done4", done4, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    d4 = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (done4 && d4 < 0) d4 = n;
    end
    check("rescan_done4_cycle", d4, 28);
    check("rescan_cap4", cap4, 7'b1011001);

    // random phase, model checked every cycle inside tick()
    for (int n = 0; n < 900; n++) begin
      rst   = ($urandom_range(99) == 0);
      start = ($urandom_range(7) == 0);
      hold  = ($urandom_range(3) == 0);
      if ($urandom_range(31) == 0) pat = 7'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
